// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the vblank scheduler state encoding.
package vga_timing_pkg;
  localparam int H_DISPLAY = 640;
  localparam int H_MAX     = 799;
  localparam int V_DISPLAY = 480;
  localparam int V_MAX     = 524;

  typedef enum logic [1:0] {IDLE, ARB, GRANT} sched_state_t;
endpackage

// File: rtl/vbl_prio_pick.sv
// Combinational fixed-priority picker: the lowest set index of pending wins.
module vbl_prio_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] pending,
  output logic [N-1:0] onehot,
  output logic [W-1:0] id,
  output logic         any
);
  // Scan from the top so the last hit, the lowest index, is the one that sticks.
  always_comb begin
    onehot = '0;
    id     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        id        = W'(i);
      end
    end
    any = |pending;
  end
endmodule

// File: rtl/vblank_update_scheduler.sv
// Grants the vblank window to one update requester at a time, lowest index first.
// Define VBL_SCHED_WATCHDOG_EN to revoke outstanding work at the end of vblank.
module vblank_update_scheduler #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int H_MAX     = vga_timing_pkg::H_MAX,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_MAX     = vga_timing_pkg::V_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             frame_tick,
  output logic             busy,
  output logic             overrun
);
  import vga_timing_pkg::*;

  sched_state_t     state, state_nxt;
  logic [N_REQ-1:0] pending, pending_nxt, pending_left, grant_nxt, pick_onehot;
  logic [ID_W-1:0]  grant_id_nxt, pick_id;
  logic             pick_any, frame_tick_nxt, overrun_nxt;
  logic             vbl_start, vbl_end, done_hit;

  assign vbl_start = (x == 10'd0) && (y == 10'(V_DISPLAY));
  assign vbl_end   = (x == 10'(H_MAX)) && (y == 10'(V_MAX));
  assign busy      = (state != IDLE);

  // Only a done from the current grant holder counts; everything else is noise.
  assign done_hit     = (state == GRANT) && |(done & grant);
  assign pending_left = done_hit ? (pending & ~grant) : pending;

  vbl_prio_pick #(.N(N_REQ), .W(ID_W)) u_pick (
    .pending (pending),
    .onehot  (pick_onehot),
    .id      (pick_id),
    .any     (pick_any)
  );

  always_comb begin
    state_nxt      = state;
    pending_nxt    = pending_left;
    grant_nxt      = grant;
    grant_id_nxt   = grant_id;
    frame_tick_nxt = vbl_start;
    overrun_nxt    = 1'b0;
    if (vbl_start) pending_nxt = pending_left | req;
    case (state)
      IDLE:  if (vbl_start) state_nxt = ARB;
      ARB: begin
        if (pick_any) begin
          grant_nxt    = pick_onehot;
          grant_id_nxt = pick_id;
          state_nxt    = GRANT;
        end else if (pending_nxt == '0) begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (done_hit) begin
          grant_nxt    = '0;
          grant_id_nxt = '0;
          state_nxt    = ARB;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef VBL_SCHED_WATCHDOG_EN
    // A done landing on vbl_end is honoured before deciding whether work was lost.
    if (vbl_end && busy) begin
      overrun_nxt  = |pending_left;
      pending_nxt  = '0;
      grant_nxt    = '0;
      grant_id_nxt = '0;
      state_nxt    = IDLE;
    end
`else
    overrun_nxt = vbl_end & 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      grant      <= '0;
      grant_id   <= '0;
      frame_tick <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      grant      <= grant_nxt;
      grant_id   <= grant_id_nxt;
      frame_tick <= frame_tick_nxt;
      overrun    <= overrun_nxt;
    end
  end
endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Randomized bench for vblank_update_scheduler against a transaction-level model.
// Follows VBL_SCHED_WATCHDOG_EN the same way the design does.
module tb_vblank_update_scheduler;
  logic       clk, reset;
  logic [9:0] x, y;
  logic [3:0] req, done, grant;
  logic [1:0] grant_id;
  logic       frame_tick, busy, overrun;

  int errors = 0;
  int checks = 0;

  // model: who holds the window, what is still owed, and whether a pick is due
  int         m_idx;
  bit         m_arb;
  logic [3:0] m_pend;
  bit         m_ft, m_ov;

  vblank_update_scheduler dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .req(req), .done(done),
    .grant(grant), .grant_id(grant_id), .frame_tick(frame_tick),
    .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_idx = -1; m_arb = 0; m_pend = '0; m_ft = 0; m_ov = 0;
  endtask

  task automatic model_step(input bit vs, input bit ve, input logic [3:0] rq, input logic [3:0] dn);
    int nidx; bit narb, was_busy; logic [3:0] np;
    was_busy = m_arb || (m_idx >= 0);
    nidx = m_idx; narb = m_arb; np = m_pend;
    m_ft = vs; m_ov = 0;
    if (m_idx >= 0) begin
      if (dn[m_idx]) begin np[m_idx] = 1'b0; nidx = -1; narb = 1; end
    end else if (m_arb) begin
      if (m_pend != 0) begin nidx = lowest(m_pend); narb = 0; end
      else narb = vs && (rq != 0);
    end
    if (vs) begin
      np = np | rq;
      if (!was_busy) narb = 1;
    end
`ifdef VBL_SCHED_WATCHDOG_EN
    if (ve && was_busy) begin
      m_ov = (np != 0); np = '0; nidx = -1; narb = 0;
    end
`endif
    m_idx = nidx; m_arb = narb; m_pend = np;
  endtask

  task automatic check_all();
    chk("grant", grant, (m_idx >= 0) ? (32'd1 << m_idx) : 32'd0);
    chk("grant_id", grant_id, (m_idx >= 0) ? m_idx : 0);
    chk("frame_tick", frame_tick, m_ft);
    chk("busy", busy, m_arb || (m_idx >= 0));
    chk("overrun", overrun, m_ov);
  endtask

  // one clock: drive pixel position and handshakes, then compare after the edge
  task automatic step(input bit vs, input bit ve, input logic [3:0] rq, input logic [3:0] dn);
    if (vs) begin x = 10'd0; y = 10'd480; end
    else if (ve) begin x = 10'd799; y = 10'd524; end
    else begin x = 10'($urandom_range(1, 798)); y = 10'($urandom_range(0, 470)); end
    req = rq; done = dn;
    @(posedge clk);
    model_step(vs, ve, rq, dn);
    #1 check_all();
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (m_arb || m_idx >= 0); k++)
      step(0, 0, 4'b0, (m_idx >= 0) ? 4'(1 << m_idx) : 4'b0);
    chk("drain_idle", busy, 1'b0);
  endtask

  initial begin
    x = '0; y = '0; req = '0; done = '0;
    reset = 1'b1;
    model_reset();
    #12;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;

    // fixed-priority order 0,1,3 with a dropped req and a stray done on the way
    step(1, 0, 4'b1011, 4'b0);
    chk("t1_tick", frame_tick, 1);
    step(0, 0, 4'b1011, 4'b0);
    chk("t1_first", grant, 4'b0001);
    step(0, 0, 4'b1011, 4'b0001);
    chk("t1_drop0", grant, 4'b0000);
    step(0, 0, 4'b1011, 4'b0);
    chk("t1_g1", grant, 4'b0010);
    step(0, 0, 4'b1001, 4'b0100);
    chk("t3_hold", grant, 4'b0010);
    step(0, 0, 4'b1001, 4'b0);
    chk("t3_hold_id", grant_id, 2'd1);
    step(0, 0, 4'b1001, 4'b0010);
    step(0, 0, 4'b1001, 4'b0);
    chk("t1_g3", grant, 4'b1000);
    step(0, 0, 4'b0, 4'b1000);
    chk("t1_busy_tail", busy, 1);
    step(0, 0, 4'b0, 4'b0);
    chk("t1_idle", busy, 0);

    // empty snapshot
    step(1, 0, 4'b0, 4'b0);
    chk("t2_busy_arb", busy, 1);
    step(0, 0, 4'b0, 4'b0);
    chk("t2_idle", busy, 0);
    chk("t2_nogrant", grant, 0);

    // grant 0 never finished, then vblank ends
    step(1, 0, 4'b0001, 4'b0);
    step(0, 0, 4'b0001, 4'b0);
    for (int k = 0; k < 5; k++) step(0, 0, 4'b0, 4'b0);
    step(0, 1, 4'b0, 4'b0);
`ifdef VBL_SCHED_WATCHDOG_EN
    chk("t4_revoke", grant, 0);
    chk("t4_ovr", overrun, 1);
`else
    chk("t5_held", grant, 4'b0001);
    chk("t5_no_ovr", overrun, 0);
`endif
    for (int k = 0; k < 3; k++) step(0, 0, 4'b0, 4'b0);
    step(1, 0, 4'b0100, 4'b0);
    chk("t45_tick", frame_tick, 1);
    drain();

    // async reset in the middle of a grant
    step(1, 0, 4'b0011, 4'b0);
    step(0, 0, 4'b0011, 4'b0);
    chk("t6_pre", grant, 4'b0001);
    #2 reset = 1'b1;
    #1;
    chk("t6_grant", grant, 0);
    chk("t6_busy", busy, 0);
    chk("t6_id", grant_id, 0);
    model_reset();
    #3 reset = 1'b0;
    step(1, 0, 4'b0010, 4'b0);
    drain();

    // randomized frames: levels on req, random completions and stray dones
    for (int f = 0; f < 40; f++) begin
      step(1, 0, 4'($urandom_range(0, 15)), 4'b0);
      for (int c = 0; c < 30; c++) begin
        logic [3:0] dn;
        dn = '0;
        if (m_idx >= 0 && $urandom_range(0, 2) == 0) dn = 4'(1 << m_idx);
        if ($urandom_range(0, 6) == 0) dn = dn | 4'($urandom_range(0, 15));
        step(0, 0, 4'($urandom_range(0, 15)), dn);
      end
      step(0, 1, 4'($urandom_range(0, 15)),
           (m_idx >= 0 && $urandom_range(0, 1) == 0) ? 4'(1 << m_idx) : 4'b0);
      for (int c = 0; c < 4; c++) step(0, 0, 4'($urandom_range(0, 15)), 4'b0);
      if (f % 8 == 7) drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
